// File: rtl/rf_node_stage_if.sv
// Handshake and bus bundle for one rf_node_stage.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface rf_node_stage_if #(
  parameter int SAMPLE_SIZE = 4,
  parameter int DATA_SIZE   = 8,
  parameter int NUM_NODES   = 16,
  parameter int OUT_SIZE    = 12
);
  localparam int IDX_W = $clog2(NUM_NODES);

  logic                             memRdy;
  logic                             validIdx;
  logic                             validSamp;
  logic                             received;
  logic [SAMPLE_SIZE*DATA_SIZE-1:0] samplesIn;
  logic [IDX_W-1:0]                 nodeIdxIn;
  logic [SAMPLE_SIZE*DATA_SIZE-1:0] samplesOut;
  logic [IDX_W-1:0]                 nodeIdxOut;
  logic [OUT_SIZE-1:0]              dataOut;
  logic                             idxErr;
  logic                             validBottom;
  logic                             validRight;
  logic                             bottomRec;
  logic                             rightRec;
  logic [IDX_W-1:0]                 memReqOut;
  logic                             reqRdy;
  logic                             dataRdy;
  logic [3*DATA_SIZE-1:0]           memBusIn;

  modport slave (
    input  memRdy, validIdx, validSamp, samplesIn, nodeIdxIn,
           bottomRec, rightRec, dataRdy, memBusIn,
    output received, samplesOut, nodeIdxOut, dataOut, idxErr,
           validBottom, validRight, memReqOut, reqRdy
  );

  modport master (
    output memRdy, validIdx, validSamp, samplesIn, nodeIdxIn,
           bottomRec, rightRec, dataRdy, memBusIn,
    input  received, samplesOut, nodeIdxOut, dataOut, idxErr,
           validBottom, validRight, memReqOut, reqRdy
  );
endinterface

// File: rtl/rf_node_stage.sv
// Random-forest node stage: queued samples, one node-memory fetch per sample,
// then a branch (child index) or leaf (saturated score) result offered to two consumers.
module rf_node_stage #(
  parameter int SAMPLE_SIZE = 4,
  parameter int DATA_SIZE   = 8,
  parameter int NUM_NODES   = 16,
  parameter int LEAF        = 0,
  parameter int FIFO_DEPTH  = 2,
  parameter int OUT_SIZE    = 12
) (
  input logic            clk,
  input logic            rst_n,
  rf_node_stage_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_NODES);
  localparam int SW    = SAMPLE_SIZE * DATA_SIZE;
  localparam int EW    = SW + IDX_W;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int MW    = 2 * DATA_SIZE + 1;

  typedef enum logic [1:0] {IDLE, REQ, COMPUTE, PROCEED} state_t;

  state_t                 state_q, state_d;
  logic [EW-1:0]          fifo_q [FIFO_DEPTH];
  logic [EW-1:0]          fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   b_flag_q, b_flag_d, r_flag_q, r_flag_d;
  logic [3*DATA_SIZE-1:0] mem_q, mem_d;
  logic [IDX_W-1:0]       node_idx_q, node_idx_d;
  logic [OUT_SIZE-1:0]    data_q, data_d;
  logic                   idx_err_q, idx_err_d;

  logic [EW-1:0]          head;
  logic [SW-1:0]          head_samp;
  logic [IDX_W-1:0]       head_idx;
  logic                   empty, full, push, pop;
  logic                   valid_b, valid_r, b_done, r_done;
  logic [DATA_SIZE-1:0]   samp_idx, thr, off, feat;
  logic                   sel_err;
  logic [IDX_W:0]         child;
  logic [MW-1:0]          sum;
  logic [OUT_SIZE-1:0]    score;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    head      = fifo_q[rd_ptr_q];
    head_samp = head[EW-1 -: SW];
    head_idx  = head[IDX_W-1:0];
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    valid_b   = (state_q == PROCEED) && !b_flag_q;
    valid_r   = (state_q == PROCEED) && !r_flag_q;
    b_done    = b_flag_q || (bus.bottomRec && valid_b);
    r_done    = r_flag_q || (bus.rightRec && valid_r);
    pop       = bus.memRdy && (state_q == PROCEED) && b_done && r_done;
    // A pop in this cycle frees the slot, so a full queue can still accept.
    push      = bus.memRdy && bus.validIdx && bus.validSamp && (!full || pop);
  end

  always_comb begin
    samp_idx = mem_q[3*DATA_SIZE-1 -: DATA_SIZE];
    thr      = mem_q[2*DATA_SIZE-1 -: DATA_SIZE];
    off      = mem_q[DATA_SIZE-1:0];
    sel_err  = (32'(samp_idx) >= 32'(SAMPLE_SIZE));
    feat     = head_samp[DATA_SIZE-1:0];
    for (int unsigned k = 0; k < SAMPLE_SIZE; k++) begin
      if (32'(samp_idx) == k) feat = head_samp[DATA_SIZE*k +: DATA_SIZE];
    end
    // Top bit of child is what 2*idx loses when truncated back to IDX_W.
    child = {head_idx, (feat > thr)};
    sum   = MW'(feat) * MW'(thr) + MW'(off);
    score = ((sum >> OUT_SIZE) != '0) ? '1 : sum[OUT_SIZE-1:0];
  end

  always_comb begin
    state_d    = state_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    b_flag_d   = b_flag_q;
    r_flag_d   = r_flag_q;
    mem_d      = mem_q;
    node_idx_d = node_idx_q;
    data_d     = data_q;
    idx_err_d  = idx_err_q;

    if (push) begin
      fifo_d[wr_ptr_q] = {bus.samplesIn, bus.nodeIdxIn};
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: if (!empty) state_d = REQ;
      REQ: begin
        if (bus.dataRdy) begin
          mem_d   = bus.memBusIn;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        idx_err_d  = sel_err || ((LEAF == 0) && child[IDX_W]);
        node_idx_d = (LEAF == 0) ? child[IDX_W-1:0] : '0;
        data_d     = (LEAF != 0) ? score : '0;
        b_flag_d   = 1'b0;
        r_flag_d   = 1'b0;
        state_d    = PROCEED;
      end
      PROCEED: begin
        b_flag_d = b_done;
        r_flag_d = r_done;
        if (pop) begin
          b_flag_d = 1'b0;
          r_flag_d = 1'b0;
          state_d  = (count_d != '0) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!bus.memRdy) begin
      state_d   = IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      b_flag_d  = 1'b0;
      r_flag_d  = 1'b0;
      idx_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      b_flag_q   <= 1'b0;
      r_flag_q   <= 1'b0;
      mem_q      <= '0;
      node_idx_q <= '0;
      data_q     <= '0;
      idx_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      b_flag_q   <= b_flag_d;
      r_flag_q   <= r_flag_d;
      mem_q      <= mem_d;
      node_idx_q <= node_idx_d;
      data_q     <= data_d;
      idx_err_q  <= idx_err_d;
    end
  end

  assign bus.received    = push;
  assign bus.samplesOut  = empty ? '0 : head_samp;
  assign bus.nodeIdxOut  = node_idx_q;
  assign bus.dataOut     = data_q;
  assign bus.idxErr      = idx_err_q;
  assign bus.validBottom = valid_b;
  assign bus.validRight  = valid_r;
  assign bus.memReqOut   = (state_q == REQ) ? head_idx : '0;
  assign bus.reqRdy      = (state_q == REQ);
endmodule

// File: tb/tb_rf_node_stage.sv
// Directed bench: a branch and a leaf instance run in lock-step on identical stimulus.
module tb_rf_node_stage;
  logic        clk;
  logic        rst_n;
  logic        memRdy, validIdx, validSamp, bottomRec, rightRec, dataRdy;
  logic [31:0] samplesIn;
  logic [3:0]  nodeIdxIn;
  logic [23:0] memBusIn;
  int          checks;
  int          errors;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] samp;
    logic [23:0] mem;
    logic [3:0]  exp_node;
    logic        exp_err_b;
    logic [11:0] exp_data;
    logic        exp_err_l;
  } vec_t;

  vec_t vecs [9];

  rf_node_stage_if #(.SAMPLE_SIZE(4), .DATA_SIZE(8), .NUM_NODES(16), .OUT_SIZE(12)) ib ();
  rf_node_stage_if #(.SAMPLE_SIZE(4), .DATA_SIZE(8), .NUM_NODES(16), .OUT_SIZE(12)) il ();

  rf_node_stage #(.SAMPLE_SIZE(4), .DATA_SIZE(8), .NUM_NODES(16), .LEAF(0),
                  .FIFO_DEPTH(2), .OUT_SIZE(12)) u_branch (.clk(clk), .rst_n(rst_n), .bus(ib));
  rf_node_stage #(.SAMPLE_SIZE(4), .DATA_SIZE(8), .NUM_NODES(16), .LEAF(1),
                  .FIFO_DEPTH(2), .OUT_SIZE(12)) u_leaf (.clk(clk), .rst_n(rst_n), .bus(il));

  assign ib.memRdy = memRdy;       assign il.memRdy = memRdy;
  assign ib.validIdx = validIdx;   assign il.validIdx = validIdx;
  assign ib.validSamp = validSamp; assign il.validSamp = validSamp;
  assign ib.samplesIn = samplesIn; assign il.samplesIn = samplesIn;
  assign ib.nodeIdxIn = nodeIdxIn; assign il.nodeIdxIn = nodeIdxIn;
  assign ib.bottomRec = bottomRec; assign il.bottomRec = bottomRec;
  assign ib.rightRec = rightRec;   assign il.rightRec = rightRec;
  assign ib.dataRdy = dataRdy;     assign il.dataRdy = dataRdy;
  assign ib.memBusIn = memBusIn;   assign il.memBusIn = memBusIn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic hands(input string tag, input logic vb, input logic vr, input logic rq);
    chk({tag, "_vbot_b"}, 32'(ib.validBottom), 32'(vb));
    chk({tag, "_vbot_l"}, 32'(il.validBottom), 32'(vb));
    chk({tag, "_vrgt_b"}, 32'(ib.validRight), 32'(vr));
    chk({tag, "_vrgt_l"}, 32'(il.validRight), 32'(vr));
    chk({tag, "_req_b"}, 32'(ib.reqRdy), 32'(rq));
    chk({tag, "_req_l"}, 32'(il.reqRdy), 32'(rq));
  endtask

  task automatic push(input vec_t v, input logic exp_rec, input string tag);
    validIdx  = 1'b1;
    validSamp = 1'b1;
    samplesIn = v.samp;
    nodeIdxIn = v.idx;
    settle();
    chk({tag, "_recv_b"}, 32'(ib.received), 32'(exp_rec));
    chk({tag, "_recv_l"}, 32'(il.received), 32'(exp_rec));
  endtask

  task automatic unpush();
    validIdx  = 1'b0;
    validSamp = 1'b0;
  endtask

  // Expects REQ on entry; leaves both stages in PROCEED with the result checked.
  task automatic serve(input vec_t v, input string tag);
    chk({tag, "_reqrdy"}, 32'(ib.reqRdy), 32'd1);
    chk({tag, "_addr_b"}, 32'(ib.memReqOut), 32'(v.idx));
    chk({tag, "_addr_l"}, 32'(il.memReqOut), 32'(v.idx));
    memBusIn = v.mem;
    dataRdy  = 1'b1;
    step();
    dataRdy  = 1'b0;
    memBusIn = '0;
    hands({tag, "_cmp"}, 1'b0, 1'b0, 1'b0);
    step();
    hands({tag, "_prc"}, 1'b1, 1'b1, 1'b0);
    chk({tag, "_node_b"}, 32'(ib.nodeIdxOut), 32'(v.exp_node));
    chk({tag, "_err_b"}, 32'(ib.idxErr), 32'(v.exp_err_b));
    chk({tag, "_data_b"}, 32'(ib.dataOut), 32'd0);
    chk({tag, "_node_l"}, 32'(il.nodeIdxOut), 32'd0);
    chk({tag, "_data_l"}, 32'(il.dataOut), 32'(v.exp_data));
    chk({tag, "_err_l"}, 32'(il.idxErr), 32'(v.exp_err_l));
    chk({tag, "_samp"}, ib.samplesOut, v.samp);
  endtask

  task automatic take();
    bottomRec = 1'b1;
    rightRec  = 1'b1;
    step();
    bottomRec = 1'b0;
    rightRec  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    push(v, 1'b1, tag);
    step();
    unpush();
    settle();
    hands({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
    step();
    serve(v, tag);
    take();
    hands({tag, "_pop"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //          idx    samples        mem            node   errb  data     errl
    vecs[0] = '{4'd3,  32'h33502211, 24'h024000,    4'd7,  1'b0, 12'hFFF, 1'b0};
    vecs[1] = '{4'd5,  32'h2010C805, 24'h011E64,    4'd11, 1'b0, 12'hFFF, 1'b0};
    vecs[2] = '{4'd4,  32'h0AFFFFFF, 24'h030305,    4'd9,  1'b0, 12'h023, 1'b0};
    vecs[3] = '{4'd2,  32'h00000040, 24'h003F3E,    4'd5,  1'b0, 12'hFFE, 1'b0};
    vecs[4] = '{4'd6,  32'h00000040, 24'h004000,    4'd12, 1'b0, 12'hFFF, 1'b0};
    vecs[5] = '{4'd1,  32'hFFFFFF09, 24'h071002,    4'd2,  1'b1, 12'h092, 1'b1};
    vecs[6] = '{4'd15, 32'h00010000, 24'h020007,    4'd15, 1'b1, 12'h007, 1'b0};
    vecs[7] = '{4'd8,  32'h01010100, 24'h0000FF,    4'd0,  1'b1, 12'h0FF, 1'b0};
    vecs[8] = '{4'd7,  32'h81000000, 24'h038000,    4'd15, 1'b0, 12'hFFF, 1'b0};

    rst_n = 1'b0; memRdy = 1'b0; validIdx = 1'b0; validSamp = 1'b0;
    bottomRec = 1'b0; rightRec = 1'b0; dataRdy = 1'b0;
    samplesIn = '0; nodeIdxIn = '0; memBusIn = '0;
    repeat (2) @(posedge clk);
    #1;
    hands("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_recv", 32'(ib.received), 32'd0);
    chk("rst_err_b", 32'(ib.idxErr), 32'd0);
    chk("rst_node_b", 32'(ib.nodeIdxOut), 32'd0);
    chk("rst_data_l", 32'(il.dataOut), 32'd0);
    chk("rst_addr_b", 32'(ib.memReqOut), 32'd0);
    chk("rst_samp_b", ib.samplesOut, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    memRdy = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Staggered consumers: bottom at N, right at N+3.
    push(vecs[0], 1'b1, "ra"); step(); unpush(); step();
    serve(vecs[0], "ra");
    bottomRec = 1'b1; step(); bottomRec = 1'b0; settle();
    hands("r_n1", 1'b0, 1'b1, 1'b0);
    bottomRec = 1'b1; step(); bottomRec = 1'b0;
    hands("r_n2", 1'b0, 1'b1, 1'b0);
    chk("r_hold_node", 32'(ib.nodeIdxOut), 32'd7);
    step();
    hands("r_n3", 1'b0, 1'b1, 1'b0);
    rightRec = 1'b1; step(); rightRec = 1'b0;
    hands("r_n4", 1'b0, 1'b0, 1'b0);
    step();
    hands("r_n5", 1'b0, 1'b0, 1'b0);

    // Full queue with stalled consumers; third sample enters on the pop cycle.
    push(vecs[0], 1'b1, "qa"); step();
    push(vecs[1], 1'b1, "qb"); step();
    push(vecs[2], 1'b0, "qc_full");
    serve(vecs[0], "qa");
    settle();
    chk("qc_stall_recv", 32'(ib.received), 32'd0);
    step();
    hands("qa_stall", 1'b1, 1'b1, 1'b0);
    chk("qa_stall_node", 32'(ib.nodeIdxOut), 32'd7);
    chk("qc_stall2_recv", 32'(il.received), 32'd0);
    bottomRec = 1'b1; rightRec = 1'b1; settle();
    chk("qc_pop_recv_b", 32'(ib.received), 32'd1);
    chk("qc_pop_recv_l", 32'(il.received), 32'd1);
    step();
    bottomRec = 1'b0; rightRec = 1'b0; unpush();
    serve(vecs[1], "qb"); take();
    serve(vecs[2], "qc"); take();
    hands("q_end", 1'b0, 1'b0, 1'b0);

    // Flush during REQ with two queued; then prove the queue restarted empty.
    push(vecs[4], 1'b1, "fa"); step();
    push(vecs[5], 1'b1, "fb"); step();
    unpush(); settle();
    hands("f_req", 1'b0, 1'b0, 1'b1);
    memRdy = 1'b0;
    push(vecs[6], 1'b0, "f_low");
    step();
    unpush(); settle();
    hands("f_flush", 1'b0, 1'b0, 1'b0);
    memRdy = 1'b1; dataRdy = 1'b1; memBusIn = vecs[4].mem;
    repeat (3) step();
    hands("f_stale", 1'b0, 1'b0, 1'b0);
    dataRdy = 1'b0; memBusIn = '0;
    push(vecs[7], 1'b1, "fc"); step();
    push(vecs[8], 1'b1, "fd"); step();
    push(vecs[0], 1'b0, "fe_full");
    chk("f_head_addr", 32'(ib.memReqOut), 32'd8);
    unpush(); memRdy = 1'b0; step();
    memRdy = 1'b1; settle();
    hands("f_clr", 1'b0, 1'b0, 1'b0);

    // Flush in PROCEED clears idxErr and the offer.
    push(vecs[5], 1'b1, "g"); step(); unpush(); step();
    serve(vecs[5], "g");
    memRdy = 1'b0; step(); memRdy = 1'b1; settle();
    hands("g_flush", 1'b0, 1'b0, 1'b0);
    chk("g_err_b", 32'(ib.idxErr), 32'd0);
    chk("g_err_l", 32'(il.idxErr), 32'd0);
    step();
    hands("g_after", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-PROCEED.
    push(vecs[6], 1'b1, "h"); step(); unpush(); step();
    serve(vecs[6], "h");
    #2 rst_n = 1'b0;
    #1;
    hands("h_rst", 1'b0, 1'b0, 1'b0);
    chk("h_rst_err_b", 32'(ib.idxErr), 32'd0);
    chk("h_rst_node_b", 32'(ib.nodeIdxOut), 32'd0);
    chk("h_rst_data_l", 32'(il.dataOut), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    hands("h_post", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
